// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters.
// One byte per grant; the next grant waits until the transmitter has started and finished the frame.
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int IDW           = 2,
  parameter int START_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        uart_din,
  output logic              uart_wr,
  input  logic              uart_te,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int            CW           = $clog2(START_TIMEOUT) + 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} state_t;

  state_t          state;
  logic [IDW-1:0]  last_grant;
  logic [CW-1:0]   timeout_cnt;
  logic [7:0]      req_bytes [NREQ];
  logic [NREQ-1:0] above_last;
  logic [NREQ-1:0] cand;
  logic [IDW-1:0]  pick_idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // Prefer requesters above the last grant; the mask is empty when last_grant is the top index.
  always_comb begin
    above_last = ~((NREQ'(2) << last_grant) - NREQ'(1));
    cand       = ((req_valid & above_last) != '0) ? (req_valid & above_last) : req_valid;
    pick_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand[IDW'(i)]) pick_idx = IDW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= IDW'(NREQ - 1);
      timeout_cnt <= '0;
      req_ready   <= '0;
      uart_din    <= '0;
      uart_wr     <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= '0;
      err_timeout <= 1'b0;
    end else begin
      uart_wr   <= 1'b0;
      req_ready <= '0;
      if (err_clr) err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (uart_te && (req_valid != '0)) begin
            uart_din   <= req_bytes[pick_idx];
            grant_id   <= pick_idx;
            last_grant <= pick_idx;
            uart_wr    <= 1'b1;
            req_ready  <= NREQ'(1) << pick_idx;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          timeout_cnt <= '0;
          state       <= WAIT_START;
        end
        // A timeout sets the sticky flag after the clear above, so the set wins.
        WAIT_START: begin
          timeout_cnt <= timeout_cnt + CW'(1);
          if (!uart_te) begin
            state <= WAIT_DONE;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (uart_te) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters and a transmitter model checked against
// a transaction-level reference of the round-robin, hold-off and timeout rules.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TO   = 8;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data  = '0;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        uart_din;
  logic              uart_wr;
  logic              uart_te   = 1'b1;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic              err_timeout;
  logic              err_clr   = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .START_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_din(uart_din), .uart_wr(uart_wr), .uart_te(uart_te),
    .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Per-requester byte FIFOs; a requester is valid while its FIFO is non-empty.
  logic [7:0] fifo [NREQ][16];
  int head [NREQ];
  int count [NREQ];

  bit   tx_auto   = 1'b0;
  logic te_manual = 1'b1;
  int   tx_wait   = 0;
  int   tx_low    = 0;
  bit   gen_en    = 1'b0;
  int   push_pct  = 0;

  // Reference state: expected outputs for the cycle about to be sampled.
  bit             pending     = 1'b0;
  bit             saw_low     = 1'b0;
  bit             dec_prev    = 1'b0;
  int             high_cnt    = 0;
  int             last_served = NREQ - 1;
  logic           err_m       = 1'b0;
  logic [IDW-1:0] gid_m       = '0;
  logic [7:0]     din_m       = '0;
  bit             load_ok     = 1'b1;
  bit             gap_low     = 1'b0;
  int             grant_log[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pushByte(input int r, input logic [7:0] b);
    fifo[r][(head[r] + count[r]) % 16] = b;
    count[r]++;
  endtask

  function automatic int rrPick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic int totalQueued();
    int s = 0;
    for (int r = 0; r < NREQ; r++) s += count[r];
    return s;
  endfunction

  // One clock: check outputs against the reference, then drive this cycle's inputs
  // and advance the reference to what the next cycle should show.
  task automatic applyStimulus(input bit rst, input bit clr);
    bit exp_wr;
    bit dec;
    bit timeout_now;
    int g;
    @(posedge clk);
    #1;
    exp_wr = dec_prev;
    checkOutput("uart_wr", uart_wr, exp_wr);
    checkOutput("req_ready", req_ready, exp_wr ? (1 << gid_m) : 0);
    checkOutput("busy", busy, pending);
    checkOutput("grant_id", grant_id, gid_m);
    checkOutput("uart_din", uart_din, din_m);
    checkOutput("err_timeout", err_timeout, err_m);

    if (uart_wr === 1'b1) begin
      grant_log.push_back(int'(grant_id));
      if (tx_auto) checkOutput("load_gap", load_ok, 1'b1);
      load_ok = 1'b0;
      gap_low = 1'b0;
    end
    if (exp_wr) begin
      head[gid_m] = (head[gid_m] + 1) % 16;
      count[gid_m]--;
    end

    if (tx_auto) begin
      if (uart_wr === 1'b1) begin
        tx_wait = $urandom_range(3, 1);
        tx_low  = $urandom_range(6, 2);
      end else if (tx_wait > 0) begin
        tx_wait--;
        if (tx_wait == 0) uart_te = 1'b0;
      end else if (!uart_te) begin
        tx_low--;
        if (tx_low == 0) uart_te = 1'b1;
      end
    end else begin
      tx_wait = 0;
      uart_te = te_manual;
    end
    if (!uart_te) gap_low = 1'b1;
    else if (gap_low) load_ok = 1'b1;

    if (gen_en)
      for (int r = 0; r < NREQ; r++)
        if (count[r] < 3 && $urandom_range(99, 0) < push_pct) pushByte(r, 8'($urandom));
    for (int r = 0; r < NREQ; r++) begin
      req_valid[r]       = (count[r] > 0);
      req_data[8*r +: 8] = (count[r] > 0) ? fifo[r][head[r]] : 8'($urandom);
    end
    reset   = rst;
    err_clr = clr;

    dec = 1'b0;
    timeout_now = 1'b0;
    if (rst) begin
      pending = 1'b0; saw_low = 1'b0; high_cnt = 0; last_served = NREQ - 1;
      err_m = 1'b0; gid_m = '0; din_m = '0; load_ok = 1'b1;
    end else begin
      if (!pending) begin
        if (uart_te && req_valid != '0) begin
          g = rrPick(req_valid, last_served);
          dec = 1'b1;
          gid_m = IDW'(g);
          din_m = req_data[8*g +: 8];
          last_served = g;
        end
      end else if (exp_wr) begin
        high_cnt = 0;
        saw_low  = 1'b0;
      end else if (!saw_low) begin
        if (!uart_te) saw_low = 1'b1;
        else begin
          high_cnt++;
          if (high_cnt == TO) begin
            timeout_now = 1'b1;
            pending = 1'b0;
          end
        end
      end else if (uart_te) begin
        pending = 1'b0;
      end
      if (dec) pending = 1'b1;
      if (timeout_now) err_m = 1'b1;
      else if (clr) err_m = 1'b0;
    end
    dec_prev = dec;
  endtask

  initial begin
    int guard;
    int exp_order [6];
    for (int r = 0; r < NREQ; r++) begin
      head[r] = 0;
      count[r] = 0;
    end

    applyStimulus(1, 0);
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_gid", grant_id, 0);
    checkOutput("rst_ready", req_ready, 0);

    pushByte(2, 8'hA5);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("single_din", uart_din, 8'hA5);
    checkOutput("single_wr", uart_wr, 1'b1);
    checkOutput("single_ready", req_ready, 4'b0100);
    applyStimulus(0, 0);
    te_manual = 1'b0;
    repeat (97) applyStimulus(0, 0);
    checkOutput("single_busy_mid", busy, 1'b1);
    te_manual = 1'b1;
    applyStimulus(0, 0);
    checkOutput("single_busy_end", busy, 1'b1);
    applyStimulus(0, 0);
    checkOutput("single_idle", busy, 1'b0);

    te_manual = 1'b0;
    pushByte(0, 8'h3C);
    repeat (5) begin
      applyStimulus(0, 0);
      checkOutput("holdoff_wr", uart_wr, 1'b0);
    end
    te_manual = 1'b1;
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("holdoff_go", uart_wr, 1'b1);
    checkOutput("holdoff_gid", grant_id, 0);

    repeat (TO) applyStimulus(0, 0);
    checkOutput("to_early", err_timeout, 1'b0);
    applyStimulus(0, 0);
    checkOutput("to_set", err_timeout, 1'b1);
    checkOutput("to_idle", busy, 1'b0);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    checkOutput("to_clr", err_timeout, 1'b0);

    pushByte(1, 8'h5A);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("to2_load", uart_wr, 1'b1);
    repeat (TO - 1) applyStimulus(0, 0);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    checkOutput("to_set_wins", err_timeout, 1'b1);

    pushByte(0, 8'hC3);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("mid_gid", grant_id, 0);
    te_manual = 1'b0;
    repeat (4) applyStimulus(0, 0);
    checkOutput("mid_busy", busy, 1'b1);
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_wr", uart_wr, 1'b0);
    checkOutput("mid_rst_ready", req_ready, 0);
    pushByte(0, 8'h11);
    pushByte(2, 8'h22);
    te_manual = 1'b1;
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("mid_next_gid", grant_id, 0);
    checkOutput("mid_next_din", uart_din, 8'h11);
    repeat (30) applyStimulus(0, 0);

    tx_auto = 1'b1;
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    for (int r = 0; r < NREQ; r++) repeat (2) pushByte(r, 8'($urandom));
    grant_log.delete();
    guard = 0;
    while (grant_log.size() < 6 && guard < 400) begin
      applyStimulus(0, 0);
      guard++;
    end
    checkOutput("rr_bound", guard < 400, 1'b1);
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      checkOutput("rr_order", grant_log[k], exp_order[k]);

    applyStimulus(1, 0);
    gen_en = 1'b1;
    push_pct = 30;
    repeat (1500) applyStimulus(0, $urandom_range(19, 0) == 0);
    gen_en = 1'b0;
    guard = 0;
    while (totalQueued() != 0 && guard < 600) begin
      applyStimulus(0, 0);
      guard++;
    end
    checkOutput("drain", guard < 600, 1'b1);
    repeat (20) applyStimulus(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
